// File: rtl/key_conditioner.sv
// Push-button and slide-switch front end: synchronises raw inputs, debounces the
// button, and produces a clean enter level, press/release pulses, guess capture and a press count.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2,
  parameter int WIDTH           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_key_n,
  input  logic [WIDTH-1:0] i_sw,
  output logic             o_enter,
  output logic             o_press,
  output logic             o_release,
  output logic [WIDTH-1:0] o_guess,
  output logic [7:0]       o_press_count,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_ARM_PRESS   = 2'd1,
    S_HELD        = 2'd2,
    S_ARM_RELEASE = 2'd3
  } state_t;

  state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic press_next, release_next;

  // Key chain carries the inverted button, so its reset value means "not pressed".
  logic [SYNC_STAGES-1:0] key_sync;
  logic [WIDTH-1:0]       sw_sync [SYNC_STAGES];
  logic                   key_s;
  logic [WIDTH-1:0]       sw_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
    end else begin
      key_sync <= {key_sync[SYNC_STAGES-2:0], ~i_key_n};
      sw_sync[0] <= i_sw;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
    end
  end

  assign key_s = key_sync[SYNC_STAGES-1];
  assign sw_s  = sw_sync[SYNC_STAGES-1];

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      S_IDLE: begin
        if (key_s) begin
          state_next = S_ARM_PRESS;
          cnt_next   = CW'(1);
        end
      end
      S_ARM_PRESS: begin
        if (!key_s) begin
          state_next = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = S_HELD;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      S_HELD: begin
        if (!key_s) begin
          state_next = S_ARM_RELEASE;
          cnt_next   = CW'(1);
        end
      end
      S_ARM_RELEASE: begin
        if (key_s) begin
          state_next = S_HELD;
        end else if (cnt == CNT_LAST) begin
          state_next   = S_IDLE;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      o_press       <= 1'b0;
      o_release     <= 1'b0;
      o_enter       <= 1'b0;
      o_guess       <= '0;
      o_press_count <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      o_press   <= press_next;
      o_release <= release_next;
      // Enter follows the debounced level: high in HELD and while a release is still unconfirmed.
      o_enter   <= (state_next == S_HELD) || (state_next == S_ARM_RELEASE);
      if (press_next) begin
        o_guess <= sw_s;
        if (o_press_count != 8'hFF) o_press_count <= o_press_count + 8'd1;
      end
    end
  end

  assign dbg_state = state;

endmodule
